// File: rtl/dmem_pkg.sv
// Shared types and lane-steering helpers for the banked data memory.
package dmem_pkg;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    typedef enum logic [2:0] {
        ErrNone,
        ErrBoth,
        ErrRange,
        ErrWrap,
        ErrAlign
    } err_cause_e;

    // Byte index within the word that bank b carries when the access starts at offset off.
    function automatic int unsigned lane_of(input int unsigned b, input int unsigned off,
                                            input int unsigned n);
        return (b + n - off) % n;
    endfunction

    // Bank that carries byte k of the word when the access starts at offset off.
    function automatic int unsigned bank_of(input int unsigned k, input int unsigned off,
                                            input int unsigned n);
        return (off + k) % n;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte-wide synchronous RAM bank with a single read/write port.
module dmem_bank #(
    parameter int unsigned ROWS = 256,
    parameter int unsigned RA_W = 8
) (
    input  logic            clk,
    input  logic            we,
    input  logic            re,
    input  logic [RA_W-1:0] addr,
    input  logic [7:0]      wdata,
    output logic [7:0]      rdata
);

    logic [7:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_banked.sv
// Byte-addressable data memory built from byte-wide banks; clears itself after reset,
// accepts one byte/word request per cycle and answers one cycle later.
module data_memory_banked
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DEPTH          = 512,
    parameter int unsigned ALLOW_MISALIGN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dm_enable,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              byte_enable,
    input  logic              Mem_signed,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] Data_in,
    output logic              ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] Data_out,
    output logic              err,
    output logic              init_done
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned ROWS  = DEPTH / BYTES;
    localparam int unsigned RA_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned OFF_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    state_e            state_q;
    logic [RA_W-1:0]   cnt_q;
    logic              rd_pend_q;
    logic              pend_byte_q;
    logic              pend_signed_q;
    logic [OFF_W-1:0]  pend_off_q;
    logic [DATA_W-1:0] hold_q;

    logic [31:0]       addr_w;
    int unsigned       off_i;
    logic [RA_W-1:0]   row;
    err_cause_e        cause;
    logic              accept;
    logic              do_rd;
    logic              do_wr;
    logic [DATA_W-1:0] word;
    logic [7:0]        sel;

    logic [BYTES-1:0]  bank_we;
    logic [BYTES-1:0]  bank_re;
    logic [RA_W-1:0]   bank_addr  [BYTES];
    logic [7:0]        bank_wdata [BYTES];
    logic [7:0]        bank_rdata [BYTES];

    assign addr_w = 32'(address);
    assign off_i  = addr_w % BYTES;
    assign row    = RA_W'(addr_w / BYTES);

    assign ready  = (state_q == StRun) && dm_enable;
    assign accept = ready && (MemRead || MemWrite);

    always_comb begin
        cause = ErrNone;
        if (MemRead && MemWrite) begin
            cause = ErrBoth;
        end else if (addr_w >= DEPTH) begin
            cause = ErrRange;
        end else if (!byte_enable && (addr_w + BYTES - 1 >= DEPTH)) begin
            cause = ErrWrap;
        end else if (!byte_enable && ALLOW_MISALIGN == 0 && off_i != 0) begin
            cause = ErrAlign;
        end
    end

    assign do_rd = accept && (cause == ErrNone) && MemRead;
    assign do_wr = accept && (cause == ErrNone) && MemWrite;

    // Banks below the start offset hold the tail of a misaligned word on the next row.
    always_comb begin
        for (int unsigned b = 0; b < BYTES; b++) begin
            bank_addr[b]  = (b >= off_i) ? row : row + RA_W'(1);
            bank_wdata[b] = Data_in[8*lane_of(b, off_i, BYTES) +: 8];
            bank_we[b]    = do_wr && (!byte_enable || b == off_i);
            bank_re[b]    = do_rd;
            if (state_q == StInit) begin
                bank_addr[b]  = cnt_q;
                bank_wdata[b] = 8'h00;
                bank_we[b]    = 1'b1;
                bank_re[b]    = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < BYTES; g++) begin : g_bank
        dmem_bank #(
            .ROWS (ROWS),
            .RA_W (RA_W)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[g]),
            .re    (bank_re[g]),
            .addr  (bank_addr[g]),
            .wdata (bank_wdata[g]),
            .rdata (bank_rdata[g])
        );
    end

    always_comb begin
        word = '0;
        for (int unsigned k = 0; k < BYTES; k++) begin
            word[8*k +: 8] = bank_rdata[bank_of(k, 32'(pend_off_q), BYTES)];
        end
        sel = bank_rdata[pend_off_q];
        if (pend_byte_q) begin
            word = {{(DATA_W-8){pend_signed_q & sel[7]}}, sel};
        end
    end

    // Bank outputs are live only in the response cycle; afterwards the held copy is shown.
    assign Data_out = rd_pend_q ? word : hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StInit;
            cnt_q         <= '0;
            rsp_valid     <= 1'b0;
            err           <= 1'b0;
            init_done     <= 1'b0;
            rd_pend_q     <= 1'b0;
            pend_byte_q   <= 1'b0;
            pend_signed_q <= 1'b0;
            pend_off_q    <= '0;
            hold_q        <= '0;
        end else begin
            rsp_valid <= accept;
            err       <= accept && (cause != ErrNone);
            rd_pend_q <= do_rd;
            if (do_rd) begin
                pend_byte_q   <= byte_enable;
                pend_signed_q <= Mem_signed;
                pend_off_q    <= OFF_W'(off_i);
            end
            if (rd_pend_q) begin
                hold_q <= word;
            end
            if (state_q == StInit) begin
                if (cnt_q == RA_W'(ROWS - 1)) begin
                    cnt_q     <= '0;
                    state_q   <= StRun;
                    init_done <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + RA_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_banked.sv
// Bench for data_memory_banked: misaligned-capable and aligned-only copies side by side,
// checked against a byte-array model of memory contents.
module tb_data_memory_banked;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        dm_enable;
    logic        MemRead;
    logic        MemWrite;
    logic        byte_enable;
    logic        Mem_signed;
    logic [15:0] address;
    logic [15:0] Data_in;

    logic        rdy [2];
    logic        rv  [2];
    logic        er  [2];
    logic        idn [2];
    logic [15:0] dout [2];

    data_memory_banked #(
        .DATA_W         (16),
        .ADDR_W         (16),
        .DEPTH          (512),
        .ALLOW_MISALIGN (1)
    ) dut0 (
        .clk         (clk),
        .rst         (rst),
        .dm_enable   (dm_enable),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .byte_enable (byte_enable),
        .Mem_signed  (Mem_signed),
        .address     (address),
        .Data_in     (Data_in),
        .ready       (rdy[0]),
        .rsp_valid   (rv[0]),
        .Data_out    (dout[0]),
        .err         (er[0]),
        .init_done   (idn[0])
    );

    data_memory_banked #(
        .DATA_W         (16),
        .ADDR_W         (16),
        .DEPTH          (512),
        .ALLOW_MISALIGN (0)
    ) dut1 (
        .clk         (clk),
        .rst         (rst),
        .dm_enable   (dm_enable),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .byte_enable (byte_enable),
        .Mem_signed  (Mem_signed),
        .address     (address),
        .Data_in     (Data_in),
        .ready       (rdy[1]),
        .rsp_valid   (rv[1]),
        .Data_out    (dout[1]),
        .err         (er[1]),
        .init_done   (idn[1])
    );

    logic [7:0]  mem [2][512];
    logic [15:0] exp_dout [2];
    int checks = 0;
    int errors = 0;

    task automatic check1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 512; i++) mem[k][i] = 8'h00;
            exp_dout[k] = 16'h0000;
        end
    endtask

    // One request in one cycle; response checked just after the accepting edge.
    task automatic req(input string tag, input bit rd, input bit wr, input bit be, input bit sg,
                       input int a, input logic [15:0] d);
        bit acc;
        bit bad;
        logic [8:0] ai;
        logic [8:0] ai1;
        @(negedge clk);
        MemRead     = rd;
        MemWrite    = wr;
        byte_enable = be;
        Mem_signed  = sg;
        address     = 16'(a);
        Data_in     = d;
        check1({tag, " ready0"}, rdy[0], dm_enable);
        check1({tag, " ready1"}, rdy[1], dm_enable);
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        acc = dm_enable && (rd || wr);
        ai  = 9'(a);
        ai1 = 9'(a + 1);
        for (int k = 0; k < 2; k++) begin
            bad = (rd && wr) || (a >= 512) || (!be && a + 1 >= 512) || (!be && k == 1 && a % 2 == 1);
            if (acc && !bad && rd) begin
                if (be) exp_dout[k] = {{8{sg & mem[k][ai][7]}}, mem[k][ai]};
                else    exp_dout[k] = {mem[k][ai1], mem[k][ai]};
            end
            if (acc && !bad && wr) begin
                mem[k][ai] = d[7:0];
                if (!be) mem[k][ai1] = d[15:8];
            end
            check1({tag, k == 0 ? " rsp_valid0" : " rsp_valid1"}, rv[k], acc);
            check1({tag, k == 0 ? " err0" : " err1"}, er[k], acc && bad);
            check16({tag, k == 0 ? " data0" : " data1"}, dout[k], exp_dout[k]);
        end
    endtask

    // Reset for one cycle (with a read request pending) and wait out the clear walk.
    task automatic reset_and_init(input string tag);
        int low;
        int bad_rdy;
        @(negedge clk);
        rst         = 1'b1;
        MemRead     = 1'b1;
        MemWrite    = 1'b0;
        byte_enable = 1'b0;
        address     = 16'h0010;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        MemRead = 1'b0;
        model_clear();
        for (int k = 0; k < 2; k++) begin
            check1({tag, " rst rsp_valid"}, rv[k], 1'b0);
            check1({tag, " rst err"}, er[k], 1'b0);
            check1({tag, " rst init_done"}, idn[k], 1'b0);
            check16({tag, " rst data"}, dout[k], 16'h0000);
        end
        low     = 0;
        bad_rdy = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (idn[0]) break;
            low++;
            if (rdy[0] || rdy[1] || idn[1]) bad_rdy++;
        end
        check_int({tag, " init cycles"}, low, 256);
        check_int({tag, " ready during init"}, bad_rdy, 0);
        check1({tag, " ready after init"}, rdy[0], 1'b1);
        check1({tag, " init_done1"}, idn[1], 1'b1);
    endtask

    initial begin
        int r;
        int a;
        bit rd;
        bit wr;
        rst         = 1'b1;
        dm_enable   = 1'b1;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        byte_enable = 1'b0;
        Mem_signed  = 1'b0;
        address     = 16'h0000;
        Data_in     = 16'h0000;
        model_clear();

        reset_and_init("init");
        req("rd_cleared", 1, 0, 1, 0, 'h011, 16'h0);
        check16("cleared byte", dout[0], 16'h0000);

        req("wr_abcd", 0, 1, 0, 0, 'h010, 16'hABCD);
        req("rd_abcd", 1, 0, 0, 0, 'h010, 16'h0);
        check16("word abcd", dout[0], 16'hABCD);
        req("rd_sx", 1, 0, 1, 1, 'h011, 16'h0);
        check16("byte signed", dout[0], 16'hFFAB);
        req("rd_zx", 1, 0, 1, 0, 'h011, 16'h0);
        check16("byte unsigned", dout[0], 16'h00AB);

        req("wr_byte", 0, 1, 1, 0, 'h020, 16'h77EF);
        req("rd_byte_word", 1, 0, 0, 0, 'h020, 16'h0);
        check16("byte write word", dout[0], 16'h00EF);
        req("idle_after_rd", 0, 0, 0, 0, 0, 16'h0);
        check16("data held", dout[0], 16'h00EF);

        req("wr_misalign", 0, 1, 0, 0, 'h021, 16'h1234);
        check1("misalign err aligned-only", er[1], 1'b1);
        req("rd_mis_word", 1, 0, 0, 0, 'h020, 16'h0);
        check16("misaligned merge", dout[0], 16'h34EF);
        check16("aligned-only unchanged", dout[1], 16'h00EF);
        req("rd_mis_byte", 1, 0, 1, 0, 'h022, 16'h0);
        check16("misaligned hi byte", dout[0], 16'h0012);
        req("rd_mis_word2", 1, 0, 0, 0, 'h021, 16'h0);

        req("rd_range", 1, 0, 1, 0, 'h200, 16'h0);
        check1("range err", er[0], 1'b1);
        req("wr_wrap", 0, 1, 0, 0, 'h1FF, 16'h5A5A);
        check1("wrap err", er[0], 1'b1);
        req("rd_1ff", 1, 0, 1, 0, 'h1FF, 16'h0);
        check16("1ff untouched", dout[0], 16'h0000);
        req("rd_and_wr", 1, 1, 0, 0, 'h010, 16'h9999);
        check1("both err", er[0], 1'b1);
        req("rd_after_both", 1, 0, 0, 0, 'h010, 16'h0);

        dm_enable = 1'b0;
        req("disabled_wr", 0, 1, 0, 0, 'h030, 16'h5555);
        dm_enable = 1'b1;
        req("rd_disabled", 1, 0, 0, 0, 'h030, 16'h0);
        check16("disabled no write", dout[0], 16'h0000);

        for (int i = 0; i < 300; i++) begin
            r  = int'($urandom_range(0, 19));
            rd = (r < 9) || (r == 18);
            wr = (r >= 9 && r < 18) || (r == 18);
            dm_enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) a = int'($urandom_range(480, 600));
            else                            a = int'($urandom_range(0, 63));
            req("rand", rd, wr, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a,
                16'($urandom));
        end
        dm_enable = 1'b1;

        req("wr_pre_rst", 0, 1, 0, 0, 'h010, 16'hBEEF);
        reset_and_init("rerst");
        req("rd_post_rst", 1, 0, 0, 0, 'h010, 16'h0);
        check16("post reset clear", dout[0], 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
